// File: rtl/dmux_1byn_stream_pkg.sv
// Shared definitions for the 1:N stream demultiplexer: routing-mode encodings
// and the select-width helper. Optional feature macro: DMUX_BCAST_EN.
package dmux_pkg;

  localparam logic MODE_ADDR = 1'b0;
  localparam logic MODE_RR   = 1'b1;

  // Select width is clog2(n), but never less than 1 bit, so N=2 still gets a
  // usable select field.
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/dmux_1byn_stream_if.sv
// Bundle of producer-side and consumer-side stream signals for the 1:N demux.
// Handshake: a beat moves on a port in any cycle where its valid and ready
// are both high at the rising clock edge; valid never waits on ready.
// DMUX_BCAST_EN adds the bcast input.
interface dmux_1byn_stream_if
  import dmux_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 8
);
  localparam int SW = sel_width(N);

  logic            mode;
  logic            in_valid;
  logic            in_ready;
  logic [SW-1:0]   in_sel;
  logic [W-1:0]    in_data;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic [N*W-1:0]  out_data;
  logic [SW-1:0]   rr_ptr;
  logic            err;
`ifdef DMUX_BCAST_EN
  logic            bcast;
`endif

  // Environment side: drives the producer beat and the consumer readies.
  modport master (
`ifdef DMUX_BCAST_EN
    output bcast,
`endif
    output mode, in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, rr_ptr, err
  );

  // Demux side.
  modport slave (
`ifdef DMUX_BCAST_EN
    input  bcast,
`endif
    input  mode, in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, rr_ptr, err
  );

endinterface

// File: rtl/dmux_1byn_stream_slot.sv
// One-deep output register for a single demux channel. A load in the same
// cycle as a drain keeps the slot full, giving full back-to-back throughput.
module dmux_slot
  import dmux_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         drain,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         free
);

  // Valid flag: load sets it, a consumer handshake clears it, load wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (valid && drain) begin
      valid <= 1'b0;
    end
  end

  // Payload only changes on a load, so it holds while the slot is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= '0;
    end else if (load) begin
      data <= load_data;
    end
  end

  assign free = !valid || drain;

endmodule

// File: rtl/dmux_1byn_stream.sv
// Registered 1:N stream demultiplexer with addressed or round-robin routing.
// Out-of-range addressed beats are swallowed and flagged on the sticky err.
// DMUX_BCAST_EN: adds a broadcast input that loads every channel at once.
module dmux_1byn_stream
  import dmux_pkg::*;
#(
  parameter int N = 8,
  parameter int W = 8
) (
  input logic               clk,
  input logic               rst,
  dmux_1byn_stream_if.slave bus
);

  localparam int SW = sel_width(N);
  localparam logic [SW:0]   N_EXT = (SW+1)'(N);
  localparam logic [SW-1:0] LAST  = SW'(N - 1);

  logic           is_bcast;
  logic [SW-1:0]  tgt;
  logic           sel_oob;
  logic           accept;
  logic [N-1:0]   slot_free;
  logic [N-1:0]   load;
  logic [N-1:0]   vld;
  logic [W-1:0]   dat [N];
  logic [SW-1:0]  rr_ptr_q;
  logic           err_q;

`ifdef DMUX_BCAST_EN
  assign is_bcast = bus.bcast;
`else
  assign is_bcast = 1'b0;
`endif

  // Target decode and input handshake; a stalled RR target blocks the input.
  always_comb begin
    tgt      = (bus.mode == MODE_RR) ? rr_ptr_q : bus.in_sel;
    sel_oob  = !is_bcast && (bus.mode == MODE_ADDR) && ({1'b0, bus.in_sel} >= N_EXT);
    bus.in_ready = 1'b0;
    if (rst) begin
      bus.in_ready = 1'b0;
    end else if (is_bcast) begin
      bus.in_ready = &slot_free;
    end else if (sel_oob) begin
      bus.in_ready = 1'b1;
    end else begin
      bus.in_ready = slot_free[tgt];
    end
    accept = bus.in_valid && bus.in_ready;
  end

  // Per-channel load strobes.
  always_comb begin
    load = '0;
    for (int k = 0; k < N; k++) begin
      load[k] = accept && !sel_oob && (is_bcast || (tgt == SW'(k)));
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_slot
    dmux_slot #(.W(W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[k]),
      .load_data (bus.in_data),
      .drain     (bus.out_ready[k]),
      .valid     (vld[k]),
      .data      (dat[k]),
      .free      (slot_free[k])
    );
    assign bus.out_data[k*W +: W] = dat[k];
  end

  assign bus.out_valid = vld;

  // Round-robin pointer: advances on accepted unicast RR beats, wraps at N-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (accept && !is_bcast && (bus.mode == MODE_RR)) begin
      rr_ptr_q <= (rr_ptr_q == LAST) ? '0 : rr_ptr_q + 1'b1;
    end
  end

  // Sticky error for swallowed out-of-range addressed beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept && sel_oob) begin
      err_q <= 1'b1;
    end
  end

  assign bus.rr_ptr = rr_ptr_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_dmux_1byn_stream.sv
// Directed bench for the 1:N demux: main instance N=8/W=8 with a scoreboard on
// every consumer handshake, plus an N=6 instance for range-error and wrap.
// DMUX_BCAST_EN enables the broadcast step.
module tb_dmux_1byn_stream;
  import dmux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  logic [2:0]  rr_model = 3'd0;

  dmux_1byn_stream_if #(.N(8), .W(8)) bus ();
  dmux_1byn_stream_if #(.N(6), .W(8)) bus6 ();

  dmux_1byn_stream #(.N(8), .W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  dmux_1byn_stream #(.N(6), .W(8)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Scoreboard: every consumer handshake on the main instance pops one entry.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 8; k++) begin
        if (bus.out_valid[k] && bus.out_ready[k]) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_beat", 64'(k), 64'hFFFF);
          end else begin
            chk("sb_beat", {53'd0, 3'(k), bus.out_data[k*8 +: 8]}, {53'd0, exp_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    bus.mode = MODE_ADDR; bus.in_valid = 1'b1; bus.in_sel = '0; bus.in_data = '0;
    bus.out_ready = '1;
    bus6.mode = MODE_ADDR; bus6.in_valid = 1'b0; bus6.in_sel = '0; bus6.in_data = '0;
    bus6.out_ready = '1;
`ifdef DMUX_BCAST_EN
    bus.bcast = 1'b0;
    bus6.bcast = 1'b0;
`endif

    // Reset state.
    sample();
    chk("rst_in_ready_low", bus.in_ready, 0);
    tick();
    rst = 1'b0; bus.in_valid = 1'b0;
    sample();
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_rr_ptr", bus.rr_ptr, 0);
    chk("rst_err", bus.err, 0);
    chk("rst6_out_valid", bus6.out_valid, 0);

    // 1: addressed sweep, one beat per cycle, one-cycle latency.
    tick();
    for (int s = 0; s < 8; s++) begin
      bus.in_valid = 1'b1; bus.mode = MODE_ADDR;
      bus.in_sel = 3'(s); bus.in_data = 8'hA0 + 8'(s);
      sample();
      chk("t1_in_ready", bus.in_ready, 1);
      chk("t1_out_valid", bus.out_valid, (s == 0) ? 64'd0 : (64'd1 << (s - 1)));
      exp_q.push_back({3'(s), 8'hA0 + 8'(s)});
      tick();
    end
    bus.in_valid = 1'b0;
    sample();
    chk("t1_last_valid", bus.out_valid, 8'h80);
    chk("t1_last_lane", bus.out_data[63:56], 8'hA7);

    // 2: backpressure on channel 3.
    tick();
    bus.out_ready = 8'hF7; bus.in_valid = 1'b1; bus.in_sel = 3'd3; bus.in_data = 8'h31;
    sample();
    chk("t2_first_ready", bus.in_ready, 1);
    exp_q.push_back({3'd3, 8'h31});
    tick();
    bus.in_data = 8'h32;
    sample();
    chk("t2_stall_ready", bus.in_ready, 0);
    chk("t2_held_valid", bus.out_valid, 8'h08);
    chk("t2_held_data", bus.out_data[31:24], 8'h31);
    tick();
    sample();
    chk("t2_still_stalled", bus.in_ready, 0);
    tick();
    bus.out_ready = 8'hFF;
    sample();
    chk("t2_release_ready", bus.in_ready, 1);
    exp_q.push_back({3'd3, 8'h32});
    tick();
    bus.in_valid = 1'b0;
    sample();
    chk("t2_no_gap_valid", bus.out_valid, 8'h08);
    chk("t2_second_data", bus.out_data[31:24], 8'h32);
    tick();
    sample();
    chk("t2_drained", bus.out_valid, 0);

    // 3: round-robin, ten beats wrap past channel 7.
    tick();
    bus.mode = MODE_RR;
    for (int i = 1; i <= 10; i++) begin
      bus.in_valid = 1'b1; bus.in_sel = 3'd6; bus.in_data = 8'(i);
      sample();
      chk("t3_in_ready", bus.in_ready, 1);
      chk("t3_rr_ptr", bus.rr_ptr, rr_model);
      exp_q.push_back({rr_model, 8'(i)});
      rr_model = (rr_model == 3'd7) ? 3'd0 : rr_model + 3'd1;
      tick();
    end
    bus.in_valid = 1'b0;
    sample();
    chk("t3_rr_end", bus.rr_ptr, 2);
    chk("t3_last_lane", bus.out_valid, 8'h02);

    // 4: N=6 instance, out-of-range sink and RR wrap at 5.
    tick();
    bus6.in_valid = 1'b1; bus6.in_sel = 3'd7; bus6.in_data = 8'h77;
    sample();
    chk("t4_oob_ready", bus6.in_ready, 1);
    chk("t4_err_before", bus6.err, 0);
    tick();
    bus6.in_valid = 1'b0;
    sample();
    chk("t4_oob_no_valid", bus6.out_valid, 0);
    chk("t4_err_set", bus6.err, 1);
    tick();
    bus6.in_valid = 1'b1; bus6.in_sel = 3'd5; bus6.in_data = 8'h65;
    sample();
    chk("t4_err_sticky", bus6.err, 1);
    chk("t4_ch5_ready", bus6.in_ready, 1);
    tick();
    bus6.in_valid = 1'b0;
    sample();
    chk("t4_ch5_valid", bus6.out_valid, 6'h20);
    chk("t4_ch5_data", bus6.out_data[47:40], 8'h65);
    tick();
    bus6.mode = MODE_RR;
    for (int i = 0; i < 6; i++) begin
      bus6.in_valid = 1'b1; bus6.in_data = 8'(i);
      sample();
      chk("t4_rr6_ptr", bus6.rr_ptr, i);
      tick();
    end
    bus6.in_valid = 1'b0;
    sample();
    chk("t4_rr6_wrap", bus6.rr_ptr, 0);

    // 5: reset with channels 2 and 5 loaded and stalled.
    tick();
    bus.mode = MODE_ADDR; bus.out_ready = 8'hDB;
    bus.in_valid = 1'b1; bus.in_sel = 3'd2; bus.in_data = 8'h22;
    tick();
    bus.in_sel = 3'd5; bus.in_data = 8'h55;
    tick();
    bus.in_valid = 1'b0;
    sample();
    chk("t5_loaded", bus.out_valid, 8'h24);
    tick();
    rst = 1'b1; bus.in_valid = 1'b1; bus.in_sel = 3'd0;
    sample();
    chk("t5_ready_in_rst", bus.in_ready, 0);
    tick();
    rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 8'hFF;
    rr_model = 3'd0;
    sample();
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_rr_ptr", bus.rr_ptr, 0);
    chk("t5_err", bus.err, 0);
    chk("t5_err6", bus6.err, 0);

`ifdef DMUX_BCAST_EN
    // 6: broadcast waits for every slot, then fills all lanes together.
    tick();
    bus.out_ready = 8'hEF; bus.in_valid = 1'b1; bus.in_sel = 3'd4; bus.in_data = 8'h44;
    sample();
    chk("t6_ch4_ready", bus.in_ready, 1);
    exp_q.push_back({3'd4, 8'h44});
    tick();
    bus.mode = MODE_RR; bus.bcast = 1'b1; bus.in_data = 8'h5C;
    sample();
    chk("t6_bcast_stall", bus.in_ready, 0);
    tick();
    bus.out_ready = 8'hFF;
    sample();
    chk("t6_bcast_ready", bus.in_ready, 1);
    for (int k = 0; k < 8; k++) exp_q.push_back({3'(k), 8'h5C});
    tick();
    bus.in_valid = 1'b0; bus.bcast = 1'b0; bus.mode = MODE_ADDR;
    sample();
    chk("t6_all_valid", bus.out_valid, 8'hFF);
    chk("t6_all_data", bus.out_data, {8{8'h5C}});
    chk("t6_rr_hold", bus.rr_ptr, 0);
    chk("t6_err", bus.err, 0);
`endif

    tick();
    sample();
    chk("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
